frame_tx_sequencer: RTL

Controls the capture-to-UART path. On a start command from the SPART receiver, it arms the camera front end. It then drains 12-bit pixels from the capture FIFO and sends each one as two bytes through the SPART transmitter, framed by a 2-byte header and a checksum trailer. It sits between the pixel FIFO read port, the SPART RX/TX byte interfaces, and the capture front end.

---
 rtl/frame_tx_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/frame_tx_sequencer.sv
// frame_tx_sequencer
//   Drives the capture-to-UART path. A start command arms the camera front
//   end, then the block streams a frame over the SPART transmitter as
//   A5 5A, two bytes per 12-bit pixel ({4'h0,pix[11:8]}, pix[7:0]), and an
//   8-bit XOR checksum of the payload bytes.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   cmd_valid, cmd_byte        command strobe/byte from SPART RX
//   fifo_rdata, fifo_rdempty   pixel FIFO read side (data one cycle after rdreq)
//   fifo_rdreq                 one-cycle FIFO read strobe
//   tx_busy                    SPART TX shifting a byte
//   tx_start, tx_data          one-cycle transmit strobe and its byte
//   capture_arm                front-end write enable
//   busy                       frame in progress
//   frame_done                 one-cycle pulse after the checksum byte has left
//   err                        sticky status: 01 timeout, 10 aborted
module frame_tx_sequencer #(
  parameter int         PIXELS_PER_FRAME = 307200,
  parameter int         TIMEOUT_CYCLES   = 1000000,
  parameter logic [7:0] CMD_START        = 8'h43,
  parameter logic [7:0] CMD_ABORT        = 8'h41
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic [11:0] fifo_rdata,
  input  logic        fifo_rdempty,
  output logic        fifo_rdreq,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        capture_arm,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  err
);

  localparam int PCW = $clog2(PIXELS_PER_FRAME + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_FRAME);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, FETCH, WAIT_DATA, SEND_HI, SEND_LO, SEND_CSUM, DONE
  } state_t;

  state_t         state, state_n;
  logic [PCW-1:0] pix_cnt, pix_inc;
  logic [TCW-1:0] to_cnt, to_inc;
  logic [11:0]    pix;
  logic [7:0]     csum;
  logic           abort_pend;

  logic       start_cmd, abort_cmd, stopping, tx_ready;
  logic       send, rd, timeout, done_fire;
  logic [7:0] send_byte;

  assign start_cmd = cmd_valid && (cmd_byte == CMD_START) && (state == IDLE);
  assign abort_cmd = cmd_valid && (cmd_byte == CMD_ABORT) && (state != IDLE);
  // Once an abort is seen, nothing new is issued until the UART drains.
  assign stopping  = abort_cmd || abort_pend;
  // tx_start is registered, so a high tx_start means the pulse is on the
  // wire right now and tx_busy has not yet had a chance to rise.
  assign tx_ready  = !tx_busy && !tx_start;
  assign pix_inc   = pix_cnt + PCW'(1);
  assign to_inc    = to_cnt + TCW'(1);

  assign busy       = (state != IDLE);
  assign fifo_rdreq = rd && !RST;

  always_comb begin
    state_n   = state;
    send      = 1'b0;
    send_byte = 8'h00;
    rd        = 1'b0;
    timeout   = 1'b0;
    done_fire = 1'b0;
    if (stopping) begin
      if (tx_ready) state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (start_cmd) state_n = HDR0;
        HDR0: if (tx_ready) begin
          send = 1'b1; send_byte = 8'hA5; state_n = HDR1;
        end
        HDR1: if (tx_ready) begin
          send = 1'b1; send_byte = 8'h5A; state_n = FETCH;
        end
        FETCH: begin
          if (!fifo_rdempty) begin
            rd = 1'b1; state_n = WAIT_DATA;
          end else if (to_inc == TO_LAST) begin
            timeout = 1'b1; state_n = IDLE;
          end
        end
        WAIT_DATA: state_n = SEND_HI;
        SEND_HI: if (tx_ready) begin
          send = 1'b1; send_byte = {4'h0, pix[11:8]}; state_n = SEND_LO;
        end
        SEND_LO: if (tx_ready) begin
          send      = 1'b1;
          send_byte = pix[7:0];
          state_n   = (pix_cnt == PIX_LAST) ? SEND_CSUM : FETCH;
        end
        SEND_CSUM: if (tx_ready) begin
          send = 1'b1; send_byte = csum; state_n = DONE;
        end
        DONE: if (tx_ready) begin
          done_fire = 1'b1; state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      capture_arm <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 2'b00;
      pix_cnt     <= '0;
      to_cnt      <= '0;
      pix         <= 12'h000;
      csum        <= 8'h00;
      abort_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      tx_start   <= send;
      frame_done <= done_fire;
      if (send) tx_data <= send_byte;
      // Header and checksum bytes stay out of the checksum.
      if (send && (state == SEND_HI || state == SEND_LO)) csum <= csum ^ send_byte;

      if (state_n == IDLE)  abort_pend <= 1'b0;
      else if (abort_cmd)   abort_pend <= 1'b1;

      if (start_cmd) begin
        capture_arm <= 1'b1;
        err         <= 2'b00;
        pix_cnt     <= '0;
        csum        <= 8'h00;
        to_cnt      <= '0;
      end
      if (abort_cmd) begin
        capture_arm <= 1'b0;
        err         <= 2'b10;
      end
      if (timeout) begin
        capture_arm <= 1'b0;
        err         <= 2'b01;
      end

      // Counts consecutive empty cycles spent in FETCH.
      if (rd)                                to_cnt <= '0;
      else if (state == FETCH && !stopping)  to_cnt <= to_inc;

      if (state == WAIT_DATA && !stopping) begin
        pix     <= fifo_rdata;
        pix_cnt <= pix_inc;
        if (pix_inc == PIX_LAST) capture_arm <= 1'b0;
      end
    end
  end

endmodule
